// File: rtl/datapath_pkg.sv
// Shared scoreboard datapath types.
// Holds the G functional-unit status table entry layout and its null-tag constant.
package datapath_pkg;

  localparam int unsigned FUST_G_NUM_SRC = 3;
  localparam int unsigned FUST_G_TAG_W   = 5;
  localparam int unsigned FUST_G_OP_W    = 32;

  // A tag of zero means the operand has no outstanding producer.
  localparam logic [FUST_G_TAG_W-1:0] FUST_G_NULL_TAG = '0;

  // One in-flight G operation.
  typedef struct packed {
    logic                                          valid;
    logic                                          spec;
    logic [FUST_G_OP_W-1:0]                        op;
    logic [FUST_G_NUM_SRC-1:0][FUST_G_TAG_W-1:0]   t;
  } fust_g_entry_t;

endpackage

// File: rtl/fust_g_pick.sv
// Lowest-index priority encoder.
// Ports: req (request vector) -> found (any bit set), idx (lowest set index, 0 if none).
module fust_g_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/fust_g_table.sv
// Multi-entry status table for the G (GEMM) functional unit.
// Ports: CLK/RST (sync, active-high); alloc_* dispatch write port with alloc_ready/alloc_idx;
// wb_en/wb_tag result-bus wakeup; issue_* valid/ready issue port; flush/resolve speculation
// control; busy (per-entry valid) and count (number of valid entries).
module fust_g_table
  import datapath_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned NUM_SRC     = FUST_G_NUM_SRC,
  parameter int unsigned TAG_W       = FUST_G_TAG_W,
  parameter int unsigned OP_W        = FUST_G_OP_W,
  localparam int unsigned IDX_W      = $clog2(NUM_ENTRIES)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     alloc_en,
  input  logic [OP_W-1:0]          alloc_op,
  input  logic                     alloc_spec,
  input  logic [NUM_SRC*TAG_W-1:0] alloc_t,
  output logic                     alloc_ready,
  output logic [IDX_W-1:0]         alloc_idx,
  input  logic                     wb_en,
  input  logic [TAG_W-1:0]         wb_tag,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [OP_W-1:0]          issue_op,
  output logic [IDX_W-1:0]         issue_idx,
  input  logic                     flush,
  input  logic                     resolve,
  output logic [NUM_ENTRIES-1:0]   busy,
  output logic [IDX_W:0]           count
);

  localparam logic [TAG_W-1:0] NULL_TAG = TAG_W'(FUST_G_NULL_TAG);

  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [NUM_ENTRIES-1:0] spec_q, spec_d;
  logic [OP_W-1:0]        op_q [NUM_ENTRIES];
  logic [OP_W-1:0]        op_d [NUM_ENTRIES];
  logic [TAG_W-1:0]       t_q  [NUM_ENTRIES][NUM_SRC];
  logic [TAG_W-1:0]       t_d  [NUM_ENTRIES][NUM_SRC];
  logic [IDX_W:0]         count_q, count_d;
  logic                   hold_q;
  logic [IDX_W-1:0]       hold_idx_q;

  logic [NUM_ENTRIES-1:0] ready_vec;
  logic                   pick_found;
  logic [IDX_W-1:0]       pick_idx;
  logic                   wb_live;
  logic                   alloc_fire;
  logic                   issue_fire;

  assign wb_live    = wb_en && (wb_tag != NULL_TAG);
  assign alloc_fire = alloc_en && alloc_ready;
  assign issue_fire = issue_valid && issue_ready;
  assign busy       = valid_q;
  assign count      = count_q;

  // Free-slot search uses registered state only; same-cycle issue does not free a slot.
  fust_g_pick #(.N(NUM_ENTRIES), .IDX_W(IDX_W)) u_alloc_pick (
    .req   (~valid_q),
    .found (alloc_ready),
    .idx   (alloc_idx)
  );

  // Ready: valid, no outstanding tags, and not being squashed this cycle.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      ready_vec[i] = valid_q[i] && !(flush && spec_q[i]);
      for (int j = 0; j < NUM_SRC; j++) begin
        if (t_q[i][j] != NULL_TAG) ready_vec[i] = 1'b0;
      end
    end
  end

  fust_g_pick #(.N(NUM_ENTRIES), .IDX_W(IDX_W)) u_issue_pick (
    .req   (ready_vec),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // A stalled presentation is held even if a lower entry becomes ready meanwhile.
  always_comb begin
    issue_valid = pick_found;
    issue_idx   = pick_idx;
    if (hold_q && ready_vec[hold_idx_q]) begin
      issue_valid = 1'b1;
      issue_idx   = hold_idx_q;
    end
    issue_op = issue_valid ? op_q[issue_idx] : '0;
  end

  // Next-state for every entry: issue, flush, resolve, wakeup, then allocation.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      valid_d[i] = valid_q[i];
      spec_d[i]  = spec_q[i];
      op_d[i]    = op_q[i];
      for (int j = 0; j < NUM_SRC; j++) begin
        t_d[i][j] = (valid_q[i] && wb_live && (t_q[i][j] == wb_tag)) ? NULL_TAG : t_q[i][j];
      end
      if (issue_fire && (issue_idx == IDX_W'(i))) valid_d[i] = 1'b0;
      if (flush && spec_q[i])                     valid_d[i] = 1'b0;
      if (resolve && !flush && valid_q[i])        spec_d[i]  = 1'b0;
      if (alloc_fire && (alloc_idx == IDX_W'(i))) begin
        valid_d[i] = !(flush && alloc_spec);
        spec_d[i]  = alloc_spec;
        op_d[i]    = alloc_op;
        for (int j = 0; j < NUM_SRC; j++) begin
          t_d[i][j] = (wb_live && (alloc_t[j*TAG_W +: TAG_W] == wb_tag))
                      ? NULL_TAG : alloc_t[j*TAG_W +: TAG_W];
        end
      end
      count_d = count_d + (IDX_W+1)'(valid_d[i]);
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q    <= '0;
      spec_q     <= '0;
      count_q    <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        op_q[i] <= '0;
        for (int j = 0; j < NUM_SRC; j++) t_q[i][j] <= NULL_TAG;
      end
    end else begin
      valid_q    <= valid_d;
      spec_q     <= spec_d;
      count_q    <= count_d;
      hold_q     <= issue_valid && !issue_ready;
      hold_idx_q <= issue_idx;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        op_q[i] <= op_d[i];
        for (int j = 0; j < NUM_SRC; j++) t_q[i][j] <= t_d[i][j];
      end
    end
  end

endmodule
